sr_frame_rx: RTL and testbench

Receiver for the static/dynamic shift-register load link. It samples the serial triplet (CLK_uC, SEL, MOSI) driven by the FSM controller, using the system clock. It deserialises MSB-first frames into a 16-bit dynamic word or an 88-bit static word and presents each completed word with a one-cycle valid pulse. It sits on the detector/chip side as the capture end of the link and as the bench-side checker for controller simulations.

---
 rtl/sr_frame_rx.sv | 192 +++++++++++++++++++
 tb/tb_sr_frame_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_frame_rx.sv
// sr_frame_rx: capture end of the static/dynamic shift-register load link.
// Samples CLK_uC/SEL/MOSI on CLK, deserialises MSB-first frames into a
// dynamic or static word and flags completed words with one-cycle pulses.
//
// state      | meaning
// -----------+--------------------------------------------------
// IDLE       | no frame in progress, waiting for a CLK_uC rise
// SHIFT_DYN  | dynamic frame partially received
// SHIFT_STAT | static frame partially received
module sr_frame_rx #(
    parameter int SIZESRDYN    = 16,
    parameter int SIZESRSTAT   = 88,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CLK_uC,
    input  logic                  SEL,
    input  logic                  MOSI,
    output logic [SIZESRDYN-1:0]  DYN_DATA,
    output logic                  DYN_VALID,
    output logic [SIZESRSTAT-1:0] STAT_DATA,
    output logic                  STAT_VALID,
    output logic                  FRAME_ERR,
    output logic                  BUSY
);

    localparam int CW  = $clog2(SIZESRSTAT + 1);
    localparam int TW  = $clog2(IDLE_TIMEOUT + 1);
    // Shadows hold N-1 bits: the final bit goes straight from mosi_s into DATA.
    localparam int DSW = SIZESRDYN - 1;
    localparam int SSW = SIZESRSTAT - 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHIFT_DYN  = 2'd1,
        SHIFT_STAT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
    logic [TW-1:0]         to_q, to_d;
    logic [DSW-1:0]        dyn_sh_q, dyn_sh_d;
    logic [SSW-1:0]        stat_sh_q, stat_sh_d;
    logic [SIZESRDYN-1:0]  dyn_data_q, dyn_data_d;
    logic [SIZESRSTAT-1:0] stat_data_q, stat_data_d;
    logic                  dyn_valid_q, dyn_valid_d;
    logic                  stat_valid_q, stat_valid_d;
    logic                  err_q, err_d;
    logic                  accept;

    logic       clk_meta_q, clk_s_q, clk_dly_q;
    logic       sel_meta_q, sel_s_q;
    logic       mosi_meta_q, mosi_s_q;
    logic [1:0] fill_q;
    logic       armed_q;
    logic       rise;

    // Two-flop synchronisers, rise-detect delay and rise arming.
    // A rise is only honoured once clk_s has been seen low after the
    // synchroniser refilled, so a CLK_uC held high across reset is ignored.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clk_meta_q  <= 1'b0;
            clk_s_q     <= 1'b0;
            clk_dly_q   <= 1'b0;
            sel_meta_q  <= 1'b0;
            sel_s_q     <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_s_q    <= 1'b0;
            fill_q      <= 2'd0;
            armed_q     <= 1'b0;
        end else begin
            clk_meta_q  <= CLK_uC;
            clk_s_q     <= clk_meta_q;
            clk_dly_q   <= clk_s_q;
            sel_meta_q  <= SEL;
            sel_s_q     <= sel_meta_q;
            mosi_meta_q <= MOSI;
            mosi_s_q    <= mosi_meta_q;
            if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
            if (fill_q == 2'd2 && !clk_s_q) armed_q <= 1'b1;
        end
    end

    assign rise    = clk_s_q & ~clk_dly_q & armed_q;
    assign cnt_inc = cnt_q + CW'(1);

    // State register plus shadow, counter and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            to_q         <= '0;
            dyn_sh_q     <= '0;
            stat_sh_q    <= '0;
            dyn_data_q   <= '0;
            stat_data_q  <= '0;
            dyn_valid_q  <= 1'b0;
            stat_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            to_q         <= to_d;
            dyn_sh_q     <= dyn_sh_d;
            stat_sh_q    <= stat_sh_d;
            dyn_data_q   <= dyn_data_d;
            stat_data_q  <= stat_data_d;
            dyn_valid_q  <= dyn_valid_d;
            stat_valid_q <= stat_valid_d;
            err_q        <= err_d;
        end
    end

    // Next state: SEL mismatch beats a rise, a rise beats the timeout.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        to_d         = to_q;
        dyn_sh_d     = dyn_sh_q;
        stat_sh_d    = stat_sh_q;
        dyn_data_d   = dyn_data_q;
        stat_data_d  = stat_data_q;
        dyn_valid_d  = 1'b0;
        stat_valid_d = 1'b0;
        err_d        = 1'b0;
        accept       = 1'b0;

        unique case (state_q)
            IDLE: accept = rise;
            SHIFT_DYN, SHIFT_STAT: begin
                if (sel_s_q != (state_q == SHIFT_STAT)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    to_d    = '0;
                    state_d = IDLE;
                end else if (rise) begin
                    accept = 1'b1;
                end else if (to_q == TW'(IDLE_TIMEOUT)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    to_d    = '0;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // In a SHIFT state an accepted bit always matches sel_s, so sel_s
        // alone picks the register for both the first and later bits.
        if (accept) begin
            to_d = '0;
            if (sel_s_q) begin
                stat_sh_d = SSW'({stat_sh_q, mosi_s_q});
                if (cnt_inc == CW'(SIZESRSTAT)) begin
                    stat_data_d  = {stat_sh_q, mosi_s_q};
                    stat_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end else begin
                    cnt_d   = cnt_inc;
                    state_d = SHIFT_STAT;
                end
            end else begin
                dyn_sh_d = DSW'({dyn_sh_q, mosi_s_q});
                if (cnt_inc == CW'(SIZESRDYN)) begin
                    dyn_data_d  = {dyn_sh_q, mosi_s_q};
                    dyn_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d   = cnt_inc;
                    state_d = SHIFT_DYN;
                end
            end
        end
    end

    // Outputs: registered data and pulses, BUSY decoded from state.
    always_comb begin
        DYN_DATA   = dyn_data_q;
        DYN_VALID  = dyn_valid_q;
        STAT_DATA  = stat_data_q;
        STAT_VALID = stat_valid_q;
        FRAME_ERR  = err_q;
        BUSY       = (state_q != IDLE);
    end

endmodule

// File: tb/tb_sr_frame_rx.sv
// Bench for sr_frame_rx: directed link scenarios plus random frames,
// checked against a frame-level model (last complete word per type).
module tb_sr_frame_rx;

    localparam int DYN  = 16;
    localparam int STAT = 88;
    localparam int TO   = 64;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            CLK_uC = 1'b0;
    logic            SEL = 1'b0;
    logic            MOSI = 1'b0;
    logic [DYN-1:0]  DYN_DATA;
    logic            DYN_VALID;
    logic [STAT-1:0] STAT_DATA;
    logic            STAT_VALID;
    logic            FRAME_ERR;
    logic            BUSY;

    sr_frame_rx #(.SIZESRDYN(DYN), .SIZESRSTAT(STAT), .IDLE_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLK_uC(CLK_uC), .SEL(SEL), .MOSI(MOSI),
        .DYN_DATA(DYN_DATA), .DYN_VALID(DYN_VALID),
        .STAT_DATA(STAT_DATA), .STAT_VALID(STAT_VALID),
        .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // model: last complete word of each type
    logic [DYN-1:0]  exp_dyn  = '0;
    logic [STAT-1:0] exp_stat = '0;

    int cyc = 0;
    int last_rise = 0;
    int n_dyn = 0, n_stat = 0, n_err = 0;
    int t_dyn = 0, t_err = 0;
    int long_pulses = 0;
    logic pv_d = 1'b0, pv_s = 1'b0, pv_e = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (DYN_VALID)  begin n_dyn++;  t_dyn = cyc; end
        if (STAT_VALID) n_stat++;
        if (FRAME_ERR)  begin n_err++;  t_err = cyc; end
        if ((DYN_VALID && pv_d) || (STAT_VALID && pv_s) || (FRAME_ERR && pv_e))
            long_pulses++;
        pv_d = DYN_VALID;
        pv_s = STAT_VALID;
        pv_e = FRAME_ERR;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // rise-to-rise spacing is gap CLK cycles (gap >= 7)
    task automatic send_bit(input logic s, input logic b, input int gap);
        SEL  = s;
        MOSI = b;
        tick(1);
        CLK_uC = 1'b1;
        last_rise = cyc;
        tick(4);
        CLK_uC = 1'b0;
        tick(gap - 5);
    endtask

    task automatic send_frame(input logic s, input logic [STAT-1:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) send_bit(s, v[i], gap);
        tick(2);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick(3);
        checks++; if (DYN_DATA !== '0) begin errors++; $display("FAIL reset_dyn_data: got %h expected 0", DYN_DATA); end
        checks++; if (STAT_DATA !== '0) begin errors++; $display("FAIL reset_stat_data: got %h expected 0", STAT_DATA); end
        checks++; if ({DYN_VALID, STAT_VALID, FRAME_ERR} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {DYN_VALID, STAT_VALID, FRAME_ERR}); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        RST_N = 1'b1;
        tick(5);
    endtask

    task automatic test_dyn_frame();
        int d0, s0, e0;
        d0 = n_dyn; s0 = n_stat; e0 = n_err;
        send_frame(1'b0, STAT'(16'hABCD), DYN, 8);
        exp_dyn = 16'hABCD;
        checks++; if (DYN_DATA !== exp_dyn) begin errors++; $display("FAIL dyn_data: got %h expected %h", DYN_DATA, exp_dyn); end
        checks++; if (n_dyn - d0 !== 1) begin errors++; $display("FAIL dyn_valid_count: got %0d expected 1", n_dyn - d0); end
        checks++; if (t_dyn - last_rise !== 3) begin errors++; $display("FAIL dyn_latency: got %0d expected 3", t_dyn - last_rise); end
        checks++; if (n_stat - s0 !== 0 || n_err - e0 !== 0) begin errors++; $display("FAIL dyn_side_pulses: got stat=%0d err=%0d expected 0 0", n_stat - s0, n_err - e0); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL dyn_busy_after: got %b expected 0", BUSY); end
    endtask

    task automatic test_stat_frame();
        int s0, e0;
        s0 = n_stat; e0 = n_err;
        send_frame(1'b1, 88'h123456789ABCDEF1234567, STAT, 8);
        exp_stat = 88'h123456789ABCDEF1234567;
        checks++; if (STAT_DATA !== exp_stat) begin errors++; $display("FAIL stat_data: got %h expected %h", STAT_DATA, exp_stat); end
        checks++; if (n_stat - s0 !== 1) begin errors++; $display("FAIL stat_valid_count: got %0d expected 1", n_stat - s0); end
        checks++; if (DYN_DATA !== exp_dyn) begin errors++; $display("FAIL stat_dyn_hold: got %h expected %h", DYN_DATA, exp_dyn); end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL stat_err: got %0d expected 0", n_err - e0); end
    endtask

    task automatic test_back_to_back();
        int d0, s0, e0;
        d0 = n_dyn; s0 = n_stat; e0 = n_err;
        send_frame(1'b0, STAT'(16'h1234), DYN, 7);
        send_frame(1'b1, STAT'(8'hFF), STAT, 7);
        exp_dyn  = 16'h1234;
        exp_stat = STAT'(8'hFF);
        checks++; if (DYN_DATA !== exp_dyn) begin errors++; $display("FAIL b2b_dyn_data: got %h expected %h", DYN_DATA, exp_dyn); end
        checks++; if (STAT_DATA !== exp_stat) begin errors++; $display("FAIL b2b_stat_data: got %h expected %h", STAT_DATA, exp_stat); end
        checks++; if (n_dyn - d0 !== 1 || n_stat - s0 !== 1) begin errors++; $display("FAIL b2b_valid_counts: got dyn=%0d stat=%0d expected 1 1", n_dyn - d0, n_stat - s0); end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL b2b_err: got %0d expected 0", n_err - e0); end
    endtask

    task automatic test_sel_abort();
        int d0, e0;
        d0 = n_dyn; e0 = n_err;
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1, 8);
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL abort_busy_mid: got %b expected 1", BUSY); end
        SEL = 1'b1;
        tick(6);
        checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL abort_err_count: got %0d expected 1", n_err - e0); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", BUSY); end
        checks++; if (DYN_DATA !== exp_dyn || n_dyn - d0 !== 0) begin errors++; $display("FAIL abort_dyn_hold: got %h/%0d expected %h/0", DYN_DATA, n_dyn - d0, exp_dyn); end
        SEL = 1'b0;
        tick(4);
        send_frame(1'b0, STAT'(16'h00FF), DYN, 8);
        exp_dyn = 16'h00FF;
        checks++; if (DYN_DATA !== exp_dyn || n_dyn - d0 !== 1) begin errors++; $display("FAIL abort_recover: got %h/%0d expected %h/1", DYN_DATA, n_dyn - d0, exp_dyn); end
        checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL abort_err_total: got %0d expected 1", n_err - e0); end
    endtask

    task automatic test_timeout();
        int s0, e0, cap;
        logic [STAT-1:0] v;
        s0 = n_stat; e0 = n_err;
        v = {$urandom, $urandom, $urandom};
        for (int i = STAT - 1; i >= STAT - 10; i--) send_bit(1'b1, v[i], 8);
        cap = last_rise + 3;
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL timeout_busy_mid: got %b expected 1", BUSY); end
        for (int i = 0; i < 200 && n_err == e0; i++) tick(1);
        checks++;
        if (n_err == e0) begin
            errors++; $display("FAIL timeout_missing: got no FRAME_ERR expected one within 200 cycles");
        end else if (t_err - cap !== TO + 1) begin
            errors++; $display("FAIL timeout_latency: got %0d expected %0d", t_err - cap, TO + 1);
        end
        checks++; if (BUSY !== 1'b0 || STAT_DATA !== exp_stat || n_stat - s0 !== 0) begin errors++; $display("FAIL timeout_hold: got busy=%b %h expected 0 %h", BUSY, STAT_DATA, exp_stat); end

        // long but legal stalls: TO-1 cycles, then a rise landing on the timeout cycle
        e0 = n_err;
        v = {$urandom, $urandom, $urandom};
        for (int i = STAT - 1; i >= 0; i--)
            send_bit(1'b1, v[i], (i == 77) ? TO - 1 : (i == 60) ? TO + 1 : 8);
        tick(2);
        exp_stat = v;
        checks++; if (STAT_DATA !== exp_stat || n_stat - s0 !== 1) begin errors++; $display("FAIL stall_frame: got %h/%0d expected %h/1", STAT_DATA, n_stat - s0, exp_stat); end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL stall_err: got %0d expected 0", n_err - e0); end
    endtask

    task automatic test_reset_midframe();
        int d0, s0;
        logic [STAT-1:0] v;
        v = {$urandom, $urandom, $urandom};
        for (int i = STAT - 1; i >= STAT - 40; i--) send_bit(1'b1, v[i], 8);
        d0 = n_dyn; s0 = n_stat;
        RST_N  = 1'b0;
        CLK_uC = 1'b1;
        tick(1);
        checks++; if (DYN_DATA !== '0 || STAT_DATA !== '0) begin errors++; $display("FAIL rst_mid_data: got %h %h expected 0 0", DYN_DATA, STAT_DATA); end
        checks++; if ({DYN_VALID, STAT_VALID, FRAME_ERR, BUSY} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags: got %b expected 0000", {DYN_VALID, STAT_VALID, FRAME_ERR, BUSY}); end
        tick(1);
        RST_N = 1'b1;
        exp_dyn  = '0;
        exp_stat = '0;
        tick(8);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_high_clk_rise: got busy=%b expected 0", BUSY); end
        CLK_uC = 1'b0;
        tick(5);
        v = {$urandom, $urandom, $urandom};
        send_frame(1'b1, v, STAT, 8);
        exp_stat = v;
        checks++; if (STAT_DATA !== exp_stat || n_stat - s0 !== 1) begin errors++; $display("FAIL rst_recover: got %h/%0d expected %h/1", STAT_DATA, n_stat - s0, exp_stat); end
        checks++; if (DYN_DATA !== exp_dyn || n_dyn - d0 !== 0) begin errors++; $display("FAIL rst_dyn_zero: got %h/%0d expected 0/0", DYN_DATA, n_dyn - d0); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 12; f++) begin
            int d0, s0, e0, n, gap, k;
            logic s;
            logic [STAT-1:0] v;
            d0 = n_dyn; s0 = n_stat; e0 = n_err;
            s   = 1'($urandom_range(0, 1));
            n   = s ? STAT : DYN;
            gap = $urandom_range(7, 12);
            v   = {$urandom, $urandom, $urandom};
            if (!s) v = STAT'(v[DYN-1:0]);
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, n - 1);
                for (int i = n - 1; i >= n - k; i--) send_bit(s, v[i], gap);
                tick(TO + 10);
                checks++; if (n_err - e0 !== 1 || n_dyn - d0 !== 0 || n_stat - s0 !== 0) begin errors++; $display("FAIL rand_partial_%0d: got err=%0d dyn=%0d stat=%0d expected 1 0 0", f, n_err - e0, n_dyn - d0, n_stat - s0); end
            end else begin
                send_frame(s, v, n, gap);
                if (s) exp_stat = v; else exp_dyn = v[DYN-1:0];
                checks++; if (n_err - e0 !== 0 || n_dyn - d0 !== (s ? 0 : 1) || n_stat - s0 !== (s ? 1 : 0)) begin errors++; $display("FAIL rand_pulses_%0d: got err=%0d dyn=%0d stat=%0d sel=%b", f, n_err - e0, n_dyn - d0, n_stat - s0, s); end
            end
            checks++; if (DYN_DATA !== exp_dyn) begin errors++; $display("FAIL rand_dyn_%0d: got %h expected %h", f, DYN_DATA, exp_dyn); end
            checks++; if (STAT_DATA !== exp_stat) begin errors++; $display("FAIL rand_stat_%0d: got %h expected %h", f, STAT_DATA, exp_stat); end
        end
    endtask

    initial begin
        test_reset();
        test_dyn_frame();
        test_stat_frame();
        test_back_to_back();
        test_sel_abort();
        test_timeout();
        test_reset_midframe();
        test_random();
        checks++; if (long_pulses !== 0) begin errors++; $display("FAIL pulse_width: got %0d multi-cycle pulses expected 0", long_pulses); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
